// File: rtl/vga_scanout.sv
// VGA raster scan-out: pixel/line counters, sync generation and a 2-slot colour pipeline.
// Optional colour-bar test pattern enabled by defining VGA_SCANOUT_TEST_PATTERN_EN.
module vga_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_ce,
    output logic [9:0] x,
    output logic [9:0] y,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_de,
    output logic       frame_start,
    input  logic       test_en
);
    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST   = 10'(HT - 1);
    localparam logic [9:0] V_LAST   = 10'(VT - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0]  hcnt;
    logic [9:0]  vcnt;
    logic        raw_hs;
    logic        raw_vs;
    logic        raw_de;
    logic        hs1;
    logic        vs1;
    logic        de1;
    logic        pce_d1;
    logic [23:0] col1;
    logic [23:0] src_col;
    logic [23:0] pix_col;

    assign x = hcnt;
    assign y = vcnt;

    // Raw sync/enable decode of the coordinate currently on x/y
    always_comb begin
        raw_hs = ~((hcnt >= HS_BEG) && (hcnt <= HS_END));
        raw_vs = ~((vcnt >= VS_BEG) && (vcnt <= VS_END));
        raw_de = (hcnt < H_ACT) && (vcnt < V_ACT);
    end

    // Raster counters and frame-start pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt        <= 10'd0;
            vcnt        <= 10'd0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (pix_ce) begin
                if (hcnt == H_LAST) begin
                    hcnt <= 10'd0;
                    if (vcnt == V_LAST) begin
                        vcnt        <= 10'd0;
                        frame_start <= 1'b1;
                    end else begin
                        vcnt <= vcnt + 10'd1;
                    end
                end else begin
                    hcnt <= hcnt + 10'd1;
                end
            end
        end
    end

    // The source answers one clk after x/y change, so its colour is caught on the clk
    // right after a slot edge; with back-to-back slots that clk is the output edge itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pce_d1 <= 1'b0;
            col1   <= 24'd0;
        end else begin
            pce_d1 <= pix_ce;
            if (pce_d1) begin
                col1 <= {red, green, blue};
            end else begin
                col1 <= col1;
            end
        end
    end

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic        te1;
    logic [23:0] pat1;

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        bar_colour = {{8{~idx[1]}}, {8{~idx[2]}}, {8{~idx[0]}}};
    endfunction

    // Test-pattern colour and select, staged alongside the first pipeline slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            te1  <= 1'b0;
            pat1 <= 24'd0;
        end else if (pix_ce) begin
            te1  <= test_en;
            pat1 <= bar_colour(3'(hcnt / 10'(BAR_W)));
        end else begin
            te1  <= te1;
            pat1 <= pat1;
        end
    end

    assign src_col = pce_d1 ? {red, green, blue} : col1;
    assign pix_col = te1 ? pat1 : src_col;
`else
    logic unused_test_en;

    assign unused_test_en = test_en;
    assign src_col        = pce_d1 ? {red, green, blue} : col1;
    assign pix_col        = src_col;
`endif

    // Two-slot sync pipeline and blanked colour output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs1    <= 1'b1;
            vs1    <= 1'b1;
            de1    <= 1'b0;
            vga_hs <= 1'b1;
            vga_vs <= 1'b1;
            vga_de <= 1'b0;
            vga_r  <= 8'd0;
            vga_g  <= 8'd0;
            vga_b  <= 8'd0;
        end else if (pix_ce) begin
            hs1    <= raw_hs;
            vs1    <= raw_vs;
            de1    <= raw_de;
            vga_hs <= hs1;
            vga_vs <= vs1;
            vga_de <= de1;
            {vga_r, vga_g, vga_b} <= de1 ? pix_col : 24'd0;
        end else begin
            hs1    <= hs1;
            vs1    <= vs1;
            de1    <= de1;
            vga_hs <= vga_hs;
            vga_vs <= vga_vs;
            vga_de <= vga_de;
            {vga_r, vga_g, vga_b} <= {vga_r, vga_g, vga_b};
        end
    end
endmodule

// File: tb/tb_vga_scanout.sv
// Self-checking bench for vga_scanout on a reduced raster (288 x 12); behaves with or
// without VGA_SCANOUT_TEST_PATTERN_EN defined.
module tb_vga_scanout;
    localparam int HA = 256, HFP = 8, HSY = 16, HBP = 8;
    localparam int VA = 6, VFP = 2, VSY = 2, VBP = 2;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    localparam bit PAT_EN = 1'b1;
`else
    localparam bit PAT_EN = 1'b0;
`endif

    logic       clk = 1'b0, rst = 1'b0, pix_ce = 1'b0, test_en = 1'b0;
    logic [9:0] x, y;
    logic [7:0] red = 8'd0, green = 8'd0, blue = 8'd0;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_de, frame_start;

    vga_scanout #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
                  .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)) dut (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .x(x), .y(y),
        .red(red), .green(green), .blue(blue),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
        .frame_start(frame_start), .test_en(test_en));

    always #5 clk = ~clk;

    int src_mode = 0;
    // Registered pixel source: answers one clk after x/y
    always @(posedge clk) begin
        red   <= (src_mode != 0) ? 8'd255 : x[7:0];
        green <= (src_mode != 0) ? 8'd255 : y[7:0];
        blue  <= (src_mode != 0) ? 8'd255 : (x[7:0] ^ y[7:0]);
    end

    typedef struct { logic hs; logic vs; logic de; logic [23:0] rgb; int h; int v; } exp_t;
    typedef struct { int h; int v; logic hs; logic vs; logic de; } bnd_t;
    typedef struct { int n; int mode; int te; int frames; } phase_t;

    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    exp_t sb[$];
    exp_t last_exp;
    exp_t rst_e = '{1'b1, 1'b1, 1'b0, 24'd0, -1, -1};
    bnd_t bnd [13];
    phase_t phases [5];

    int n_chk = 0, n_pass = 0;
    int mh, mv, n_cur = 1, ph = 0, te_mode = 0, slot_cnt = 0, clk_idx = 0;
    int hs_fall, vs_fall, de_cnt;
    bit freeze = 1'b0, meas_en = 1'b1, exp_fs;
    logic hs_prev, vs_prev;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
    endtask

    function automatic exp_t model(input int h, input int v, input logic te);
        exp_t e;
        logic [7:0] hb, vb;
        logic [23:0] c;
        hb = 8'(h);
        vb = 8'(v);
        e.h = h;
        e.v = v;
        e.hs = !(h >= HA + HFP && h < HA + HFP + HSY);
        e.vs = !(v >= VA + VFP && v < VA + VFP + VSY);
        e.de = (h < HA) && (v < VA);
        c = (src_mode != 0) ? 24'hFFFFFF : {hb, vb, hb ^ vb};
        if (PAT_EN && te && e.de) c = bars[h / (HA / 8)];
        e.rgb = e.de ? c : 24'd0;
        return e;
    endfunction

    task automatic meas_reset();
        hs_fall = -1; vs_fall = -1; de_cnt = 0; hs_prev = 1'b1; vs_prev = 1'b1;
    endtask

    // Asserts reset mid-cycle, checks the outputs at once, then releases and restarts the model
    task automatic do_reset();
        rst = 1'b1;
        pix_ce = 1'b0;
        #1;
        check("reset_async", {x, y, vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b, frame_start},
              {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 24'd0, 1'b0});
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mh = 0; mv = 0;
        sb.delete();
        sb.push_back(rst_e);
        last_exp = rst_e;
        ph = 0; slot_cnt = 0;
        pix_ce = 1'b1;
        meas_reset();
    endtask

    task automatic step();
        bit pe;
        logic te_now;
        pe = pix_ce;
        te_now = test_en;
        @(posedge clk);
        #1;
        clk_idx++;
        exp_fs = 1'b0;
        if (pe) begin
            sb.push_back(model(mh, mv, te_now));
            mh++;
            if (mh == HT) begin
                mh = 0; mv++;
                if (mv == VT) begin mv = 0; exp_fs = 1'b1; end
            end
            last_exp = sb.pop_front();
            foreach (bnd[i])
                if (bnd[i].h == last_exp.h && bnd[i].v == last_exp.v)
                    check("boundary_sync", {vga_hs, vga_vs, vga_de}, {bnd[i].hs, bnd[i].vs, bnd[i].de});
        end
        check("xy", {x, y}, {10'(mh), 10'(mv)});
        check("vga_out", {vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b},
              {last_exp.hs, last_exp.vs, last_exp.de, last_exp.rgb});
        check("frame_start", frame_start, exp_fs);
        if (meas_en) begin
            if (hs_prev && !vga_hs) begin
                if (hs_fall >= 0) check("hs_period", clk_idx - hs_fall, HT * n_cur);
                hs_fall = clk_idx;
            end
            if (!hs_prev && vga_hs && hs_fall >= 0) check("hs_low", clk_idx - hs_fall, HSY * n_cur);
            if (vs_prev && !vga_vs) begin
                if (vs_fall >= 0) begin
                    check("vs_period", clk_idx - vs_fall, HT * VT * n_cur);
                    check("de_per_frame", de_cnt, HA * VA * n_cur);
                end
                vs_fall = clk_idx;
                de_cnt = 0;
            end
            if (!vs_prev && vga_vs && vs_fall >= 0) check("vs_low", clk_idx - vs_fall, VSY * HT * n_cur);
            if (vga_de) de_cnt++;
        end
        hs_prev = vga_hs;
        vs_prev = vga_vs;
        ph = (ph + 1) % n_cur;
        pix_ce = !freeze && (ph == 0);
        if (te_mode == 2 && pix_ce) begin
            slot_cnt++;
            if (slot_cnt % 37 == 0) test_en = ~test_en;
        end
    endtask

    initial begin
        bnd[0]  = '{0,   0,  1'b1, 1'b1, 1'b1};
        bnd[1]  = '{255, 0,  1'b1, 1'b1, 1'b1};
        bnd[2]  = '{256, 0,  1'b1, 1'b1, 1'b0};
        bnd[3]  = '{263, 0,  1'b1, 1'b1, 1'b0};
        bnd[4]  = '{264, 0,  1'b0, 1'b1, 1'b0};
        bnd[5]  = '{279, 0,  1'b0, 1'b1, 1'b0};
        bnd[6]  = '{280, 0,  1'b1, 1'b1, 1'b0};
        bnd[7]  = '{287, 5,  1'b1, 1'b1, 1'b0};
        bnd[8]  = '{0,   6,  1'b1, 1'b1, 1'b0};
        bnd[9]  = '{0,   8,  1'b1, 1'b0, 1'b0};
        bnd[10] = '{100, 9,  1'b1, 1'b0, 1'b0};
        bnd[11] = '{0,   10, 1'b1, 1'b1, 1'b0};
        bnd[12] = '{255, 5,  1'b1, 1'b1, 1'b1};
        phases[0] = '{1, 0, 0, 2};
        phases[1] = '{2, 0, 0, 2};
        phases[2] = '{1, 1, 0, 1};
        phases[3] = '{3, 0, 1, 1};
        phases[4] = '{1, 0, 2, 1};

        #2;
        foreach (phases[p]) begin
            n_cur = phases[p].n;
            src_mode = phases[p].mode;
            te_mode = phases[p].te;
            test_en = (phases[p].te == 1);
            do_reset();
            repeat (phases[p].frames * HT * VT * phases[p].n + 8) step();
        end

        // Mid-frame reset, then restart from (0,0) with no frame_start
        n_cur = 1; src_mode = 0; te_mode = 0; test_en = 1'b0;
        do_reset();
        repeat (1000) step();
        do_reset();
        repeat (600) step();

        // Long pix_ce=0 gap mid-line: everything must hold and resume aligned
        meas_en = 1'b0;
        repeat (300) step();
        freeze = 1'b1;
        repeat (15) step();
        freeze = 1'b0;
        repeat (300) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
